// File: rtl/load_store_unit.sv
// -----------------------------------------------------------------------------
// load_store_unit
//
// Memory-stage engine for the pipelined RISC-V core. One load or store is
// taken per handshake from execute, turned into a registered bus request with
// byte strobes, and tracked in an in-order queue until its response returns.
// Load responses are lane-shifted and sign/zero-extended before being handed
// to writeback. Misaligned accesses are accepted but dropped and reported.
//
// Parameters
//   XLEN   datapath / address width, 32 or 64
//   DEPTH  maximum accesses in flight (request register + awaiting response)
//
// Ports
//   i_clk, i_rst            clock, synchronous active-high reset
//   i_valid/o_ready         execute-stage handshake
//   i_addr, i_wdata, i_we,
//   i_size, i_sig, i_rd     access description
//   o_req_*/i_req_ready     memory bus request channel (registered)
//   i_rsp_valid/i_rsp_rdata memory bus response, one per request, in order
//   o_wb_*                  load result toward writeback (one-cycle pulse)
//   o_misaligned/o_exc_addr misaligned-access report
//   o_idle                  nothing in flight
// -----------------------------------------------------------------------------
module load_store_unit #(
    parameter int XLEN  = 32,
    parameter int DEPTH = 2
) (
    input  logic               i_clk,
    input  logic               i_rst,
    // execute-stage side
    input  logic               i_valid,
    output logic               o_ready,
    input  logic [XLEN-1:0]    i_addr,
    input  logic [XLEN-1:0]    i_wdata,
    input  logic               i_we,
    input  logic [1:0]         i_size,
    input  logic               i_sig,
    input  logic [4:0]         i_rd,
    // memory bus request
    output logic               o_req_valid,
    input  logic               i_req_ready,
    output logic [XLEN-1:0]    o_req_addr,
    output logic [XLEN-1:0]    o_req_wdata,
    output logic [XLEN/8-1:0]  o_req_wstrb,
    output logic               o_req_we,
    // memory bus response
    input  logic               i_rsp_valid,
    input  logic [XLEN-1:0]    i_rsp_rdata,
    // writeback side
    output logic               o_wb_valid,
    output logic [4:0]         o_wb_rd,
    output logic [XLEN-1:0]    o_wb_data,
    // exception / status
    output logic               o_misaligned,
    output logic [XLEN-1:0]    o_exc_addr,
    output logic               o_idle
);

    localparam int SB   = XLEN / 8;
    localparam int OFFW = $clog2(SB);
    localparam int PTRW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNTW = $clog2(DEPTH + 1);

    localparam logic [CNTW-1:0] DEPTH_C   = CNTW'(DEPTH);
    localparam logic [PTRW-1:0] PTR_LAST  = PTRW'(DEPTH - 1);

    typedef enum logic {
        IDLE = 1'b0,
        PEND = 1'b1
    } req_state_t;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    req_state_t         state_q, state_d;
    logic [XLEN-1:0]    req_addr_q, req_addr_d;
    logic [XLEN-1:0]    req_wdata_q, req_wdata_d;
    logic [SB-1:0]      req_wstrb_q, req_wstrb_d;
    logic               req_we_q, req_we_d;

    logic [CNTW-1:0]    count_q, count_d;
    logic [PTRW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PTRW-1:0]    rd_ptr_q, rd_ptr_d;

    logic               wb_valid_q, wb_valid_d;
    logic [4:0]         wb_rd_q, wb_rd_d;
    logic [XLEN-1:0]    wb_data_q, wb_data_d;

    logic               mis_q, mis_d;
    logic [XLEN-1:0]    exc_addr_q, exc_addr_d;

    // Tracking queue storage; plain arrays without reset so they map to
    // distributed/block memory. Validity is carried by count/pointers only.
    logic [OFFW-1:0]    q_off  [DEPTH];
    logic [1:0]         q_size [DEPTH];
    logic               q_sig  [DEPTH];
    logic               q_we   [DEPTH];
    logic [4:0]         q_rd   [DEPTH];

    // ------------------------------------------------------------------
    // Incoming access decode
    // ------------------------------------------------------------------
    logic [OFFW-1:0]    in_off;
    logic [3:0]         in_nbytes;
    logic [4:0]         in_lane_lo;
    logic [4:0]         in_lane_hi;
    logic               in_misaligned;
    logic [SB-1:0]      in_wstrb;
    logic [XLEN-1:0]    in_wdata_shifted;
    logic [XLEN-1:0]    in_addr_aligned;

    logic               accept;
    logic               push;
    logic               pop;

    assign in_off           = i_addr[OFFW-1:0];
    assign in_nbytes        = 4'd1 << i_size;
    assign in_lane_lo       = 5'(in_off);
    assign in_lane_hi       = 5'(in_off) + 5'(in_nbytes);
    assign in_wdata_shifted = i_wdata << {in_off, 3'b000};
    assign in_addr_aligned  = {i_addr[XLEN-1:OFFW], {OFFW{1'b0}}};

    always_comb begin
        in_misaligned = 1'b0;
        case (i_size)
            2'd1:    in_misaligned = i_addr[0];
            2'd2:    in_misaligned = |i_addr[1:0];
            // a doubleword access cannot exist on a 32-bit datapath
            2'd3:    in_misaligned = (XLEN == 32) ? 1'b1 : (|i_addr[2:0]);
            default: in_misaligned = 1'b0;
        endcase
    end

    // Byte lane gi is strobed when off <= gi < off + bytes. For aligned
    // accesses the window never runs past the top lane.
    generate
        for (genvar gi = 0; gi < SB; gi++) begin : g_wstrb
            assign in_wstrb[gi] = (5'(gi) >= in_lane_lo) && (5'(gi) < in_lane_hi);
        end
    endgenerate

    // The request register is free when nothing is pending or the pending
    // request is leaving this very cycle, which gives one request per cycle.
    assign o_ready = (count_q < DEPTH_C) && ((state_q == IDLE) || i_req_ready);
    assign accept  = i_valid && o_ready;
    assign push    = accept && !in_misaligned;
    // A response with nothing outstanding (e.g. left over from before a
    // reset) is dropped.
    assign pop     = i_rsp_valid && (count_q != '0);

    // ------------------------------------------------------------------
    // Response extraction for the queue head
    // ------------------------------------------------------------------
    logic [OFFW-1:0]    head_off;
    logic [1:0]         head_size;
    logic               head_sig;
    logic               head_we;
    logic [4:0]         head_rd;
    logic [3:0]         head_nbytes;
    logic [XLEN-1:0]    rsp_shifted;
    logic               head_sign_bit;
    logic               head_fill;
    logic [XLEN-1:0]    rsp_extended;

    assign head_off    = q_off[rd_ptr_q];
    assign head_size   = q_size[rd_ptr_q];
    assign head_sig    = q_sig[rd_ptr_q];
    assign head_we     = q_we[rd_ptr_q];
    assign head_rd     = q_rd[rd_ptr_q];
    assign head_nbytes = 4'd1 << head_size;
    assign rsp_shifted = i_rsp_rdata >> {head_off, 3'b000};

    always_comb begin
        head_sign_bit = 1'b0;
        case (head_size)
            2'd0:    head_sign_bit = rsp_shifted[7];
            2'd1:    head_sign_bit = rsp_shifted[15];
            2'd2:    head_sign_bit = rsp_shifted[31];
            default: head_sign_bit = rsp_shifted[XLEN-1];
        endcase
    end

    assign head_fill = head_sig && head_sign_bit;

    // Bytes inside the access width pass through; bytes above it are filled
    // with the extension bit.
    generate
        for (genvar gi = 0; gi < SB; gi++) begin : g_extend
            assign rsp_extended[8*gi +: 8] = (4'(gi) < head_nbytes) ?
                                             rsp_shifted[8*gi +: 8] :
                                             {8{head_fill}};
        end
    endgenerate

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d     = state_q;
        req_addr_d  = req_addr_q;
        req_wdata_d = req_wdata_q;
        req_wstrb_d = req_wstrb_q;
        req_we_d    = req_we_q;
        count_d     = count_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        wb_valid_d  = 1'b0;
        wb_rd_d     = wb_rd_q;
        wb_data_d   = wb_data_q;
        mis_d       = 1'b0;
        exc_addr_d  = exc_addr_q;

        // Request FSM. Because o_ready already folds in i_req_ready, a push
        // can only occur when the request register is free.
        case (state_q)
            IDLE: begin
                if (push) begin
                    state_d = PEND;
                end
            end
            PEND: begin
                if (i_req_ready && !push) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        if (push) begin
            req_addr_d  = in_addr_aligned;
            req_wdata_d = in_wdata_shifted;
            req_wstrb_d = in_wstrb;
            req_we_d    = i_we;
            wr_ptr_d    = (wr_ptr_q == PTR_LAST) ? '0 : wr_ptr_q + 1'b1;
        end

        if (accept && in_misaligned) begin
            mis_d      = 1'b1;
            exc_addr_d = i_addr;
        end

        if (pop) begin
            rd_ptr_d = (rd_ptr_q == PTR_LAST) ? '0 : rd_ptr_q + 1'b1;
            if (!head_we) begin
                wb_valid_d = 1'b1;
                wb_rd_d    = head_rd;
                wb_data_d  = rsp_extended;
            end
        end

        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q     <= IDLE;
            req_addr_q  <= '0;
            req_wdata_q <= '0;
            req_wstrb_q <= '0;
            req_we_q    <= 1'b0;
            count_q     <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            wb_valid_q  <= 1'b0;
            wb_rd_q     <= '0;
            wb_data_q   <= '0;
            mis_q       <= 1'b0;
            exc_addr_q  <= '0;
        end else begin
            state_q     <= state_d;
            req_addr_q  <= req_addr_d;
            req_wdata_q <= req_wdata_d;
            req_wstrb_q <= req_wstrb_d;
            req_we_q    <= req_we_d;
            count_q     <= count_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            wb_valid_q  <= wb_valid_d;
            wb_rd_q     <= wb_rd_d;
            wb_data_q   <= wb_data_d;
            mis_q       <= mis_d;
            exc_addr_q  <= exc_addr_d;
        end
    end

    always_ff @(posedge i_clk) begin
        if (push) begin
            q_off[wr_ptr_q]  <= in_off;
            q_size[wr_ptr_q] <= i_size;
            q_sig[wr_ptr_q]  <= i_sig;
            q_we[wr_ptr_q]   <= i_we;
            q_rd[wr_ptr_q]   <= i_rd;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign o_req_valid  = (state_q == PEND);
    assign o_req_addr   = req_addr_q;
    assign o_req_wdata  = req_wdata_q;
    assign o_req_wstrb  = req_wstrb_q;
    assign o_req_we     = req_we_q;
    assign o_wb_valid   = wb_valid_q;
    assign o_wb_rd      = wb_rd_q;
    assign o_wb_data    = wb_data_q;
    assign o_misaligned = mis_q;
    assign o_exc_addr   = exc_addr_q;
    assign o_idle       = (count_q == '0) && !o_req_valid;

endmodule

// File: tb/tb_load_store_unit.sv
// -----------------------------------------------------------------------------
// tb_load_store_unit
//
// Drives a 32-bit and a 64-bit instance of load_store_unit (DEPTH=2) with
// directed scenarios and a randomized run checked against a queue-based
// reference model. Inputs change on the falling edge; outputs are sampled
// on the falling edge (registered outputs) or 1 time unit after new inputs
// are applied (combinational o_ready).
// -----------------------------------------------------------------------------
module tb_load_store_unit;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;

    // 32-bit instance signals
    logic        a_valid, a_ready, a_we, a_sig;
    logic [31:0] a_addr, a_wdata;
    logic [1:0]  a_size;
    logic [4:0]  a_rd;
    logic        a_req_valid, a_req_ready, a_req_we;
    logic [31:0] a_req_addr, a_req_wdata;
    logic [3:0]  a_req_wstrb;
    logic        a_rsp_valid;
    logic [31:0] a_rsp_rdata;
    logic        a_wb_valid;
    logic [4:0]  a_wb_rd;
    logic [31:0] a_wb_data;
    logic        a_mis;
    logic [31:0] a_exc_addr;
    logic        a_idle;

    // 64-bit instance signals
    logic        b_valid, b_ready, b_we, b_sig;
    logic [63:0] b_addr, b_wdata;
    logic [1:0]  b_size;
    logic [4:0]  b_rd;
    logic        b_req_valid, b_req_ready, b_req_we;
    logic [63:0] b_req_addr, b_req_wdata;
    logic [7:0]  b_req_wstrb;
    logic        b_rsp_valid;
    logic [63:0] b_rsp_rdata;
    logic        b_wb_valid;
    logic [4:0]  b_wb_rd;
    logic [63:0] b_wb_data;
    logic        b_mis;
    logic [63:0] b_exc_addr;
    logic        b_idle;

    int errors = 0;
    int checks = 0;

    load_store_unit #(.XLEN(32), .DEPTH(2)) dut32 (
        .i_clk(clk), .i_rst(rst),
        .i_valid(a_valid), .o_ready(a_ready),
        .i_addr(a_addr), .i_wdata(a_wdata), .i_we(a_we),
        .i_size(a_size), .i_sig(a_sig), .i_rd(a_rd),
        .o_req_valid(a_req_valid), .i_req_ready(a_req_ready),
        .o_req_addr(a_req_addr), .o_req_wdata(a_req_wdata),
        .o_req_wstrb(a_req_wstrb), .o_req_we(a_req_we),
        .i_rsp_valid(a_rsp_valid), .i_rsp_rdata(a_rsp_rdata),
        .o_wb_valid(a_wb_valid), .o_wb_rd(a_wb_rd), .o_wb_data(a_wb_data),
        .o_misaligned(a_mis), .o_exc_addr(a_exc_addr), .o_idle(a_idle)
    );

    load_store_unit #(.XLEN(64), .DEPTH(2)) dut64 (
        .i_clk(clk), .i_rst(rst),
        .i_valid(b_valid), .o_ready(b_ready),
        .i_addr(b_addr), .i_wdata(b_wdata), .i_we(b_we),
        .i_size(b_size), .i_sig(b_sig), .i_rd(b_rd),
        .o_req_valid(b_req_valid), .i_req_ready(b_req_ready),
        .o_req_addr(b_req_addr), .o_req_wdata(b_req_wdata),
        .o_req_wstrb(b_req_wstrb), .o_req_we(b_req_we),
        .i_rsp_valid(b_rsp_valid), .i_rsp_rdata(b_rsp_rdata),
        .o_wb_valid(b_wb_valid), .o_wb_rd(b_wb_rd), .o_wb_data(b_wb_data),
        .o_misaligned(b_mis), .o_exc_addr(b_exc_addr), .o_idle(b_idle)
    );

    // ------------------------------------------------------------------
    // Reference model helpers (architectural rules, plain arithmetic)
    // ------------------------------------------------------------------
    typedef struct {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        logic        we;
    } req_t;

    typedef struct {
        int          off;
        int          size;
        bit          sig;
        bit          we;
        logic [4:0]  rd;
    } meta_t;

    function automatic bit model_misaligned32(logic [31:0] addr, int size);
        if (size == 3) return 1'b1;
        return (addr % (32'd1 << size)) != 0;
    endfunction

    function automatic logic [63:0] model_extend(logic [63:0] rdata, int off, int size, bit sig);
        int          nbits;
        logic [63:0] v;
        logic [63:0] mask;
        nbits = 8 << size;
        v     = rdata >> (8 * off);
        mask  = (nbits >= 64) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << nbits) - 64'd1);
        v     = v & mask;
        if (sig && v[nbits-1]) v = v | ~mask;
        return v;
    endfunction

    task automatic a_idle_inputs();
        a_valid = 0; a_we = 0; a_sig = 0; a_addr = '0; a_wdata = '0;
        a_size = 0; a_rd = 0; a_req_ready = 1; a_rsp_valid = 0; a_rsp_rdata = '0;
    endtask

    task automatic b_idle_inputs();
        b_valid = 0; b_we = 0; b_sig = 0; b_addr = '0; b_wdata = '0;
        b_size = 0; b_rd = 0; b_req_ready = 1; b_rsp_valid = 0; b_rsp_rdata = '0;
    endtask

    // ------------------------------------------------------------------
    // Scenarios
    // ------------------------------------------------------------------
    task automatic test_reset();
        rst = 1;
        a_idle_inputs();
        b_idle_inputs();
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++; if (a_req_valid !== 1'b0) begin errors++; $display("FAIL reset_req_valid: got %b want 0", a_req_valid); end
        checks++; if (a_wb_valid !== 1'b0) begin errors++; $display("FAIL reset_wb_valid: got %b want 0", a_wb_valid); end
        checks++; if (a_mis !== 1'b0) begin errors++; $display("FAIL reset_misaligned: got %b want 0", a_mis); end
        checks++; if (a_idle !== 1'b1) begin errors++; $display("FAIL reset_idle: got %b want 1", a_idle); end
        checks++; if (a_req_addr !== 32'h0) begin errors++; $display("FAIL reset_req_addr: got %h want 0", a_req_addr); end
        checks++; if (a_wb_data !== 32'h0) begin errors++; $display("FAIL reset_wb_data: got %h want 0", a_wb_data); end
        checks++; if (a_exc_addr !== 32'h0) begin errors++; $display("FAIL reset_exc_addr: got %h want 0", a_exc_addr); end
        checks++; if (b_idle !== 1'b1) begin errors++; $display("FAIL reset_idle64: got %b want 1", b_idle); end
        rst = 0;
        $display("reset: done");
    endtask

    task automatic test_store_byte();
        @(negedge clk);
        a_idle_inputs();
        a_valid = 1; a_addr = 32'h1003; a_size = 0; a_we = 1; a_wdata = 32'hAB;
        @(negedge clk);
        a_valid = 0;
        checks++; if (a_req_valid !== 1'b1) begin errors++; $display("FAIL sb_req_valid: got %b want 1", a_req_valid); end
        checks++; if (a_req_addr !== 32'h1000) begin errors++; $display("FAIL sb_req_addr: got %h want 00001000", a_req_addr); end
        checks++; if (a_req_wstrb !== 4'b1000) begin errors++; $display("FAIL sb_wstrb: got %b want 1000", a_req_wstrb); end
        checks++; if (a_req_wdata !== 32'hAB00_0000) begin errors++; $display("FAIL sb_wdata: got %h want ab000000", a_req_wdata); end
        checks++; if (a_req_we !== 1'b1) begin errors++; $display("FAIL sb_we: got %b want 1", a_req_we); end
        @(negedge clk);
        checks++; if (a_req_valid !== 1'b0) begin errors++; $display("FAIL sb_req_done: got %b want 0", a_req_valid); end
        a_rsp_valid = 1; a_rsp_rdata = $urandom;
        @(negedge clk);
        a_rsp_valid = 0;
        checks++; if (a_wb_valid !== 1'b0) begin errors++; $display("FAIL sb_no_wb: got %b want 0", a_wb_valid); end
        checks++; if (a_idle !== 1'b1) begin errors++; $display("FAIL sb_idle: got %b want 1", a_idle); end
        $display("store_byte: addr=1003 wstrb=%b wdata=%h", a_req_wstrb, a_req_wdata);
    endtask

    task automatic test_load_byte(input bit sig, input logic [31:0] want);
        @(negedge clk);
        a_idle_inputs();
        a_valid = 1; a_addr = 32'h2002; a_size = 0; a_we = 0; a_sig = sig; a_rd = 5'd5;
        @(negedge clk);
        a_valid = 0;
        @(negedge clk);
        a_rsp_valid = 1; a_rsp_rdata = 32'h0080_0000;
        checks++; if (a_wb_valid !== 1'b0) begin errors++; $display("FAIL lb_early_wb: got %b want 0", a_wb_valid); end
        @(negedge clk);
        a_rsp_valid = 0;
        checks++; if (a_wb_valid !== 1'b1) begin errors++; $display("FAIL lb_wb_valid sig=%0d: got %b want 1", sig, a_wb_valid); end
        checks++; if (a_wb_rd !== 5'd5) begin errors++; $display("FAIL lb_wb_rd: got %0d want 5", a_wb_rd); end
        checks++; if (a_wb_data !== want) begin errors++; $display("FAIL lb_wb_data sig=%0d: got %h want %h", sig, a_wb_data, want); end
        @(negedge clk);
        checks++; if (a_wb_valid !== 1'b0) begin errors++; $display("FAIL lb_wb_pulse: got %b want 0", a_wb_valid); end
        $display("load_byte: sig=%0d data=%h", sig, want);
    endtask

    task automatic test_stall();
        @(negedge clk);
        a_idle_inputs();
        a_valid = 1; a_addr = 32'h3000; a_size = 2; a_we = 1; a_wdata = 32'hCAFE_F00D;
        a_req_ready = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            a_valid = 0;
            #1;
            checks++; if (a_req_valid !== 1'b1) begin errors++; $display("FAIL stall_req_valid[%0d]: got %b want 1", i, a_req_valid); end
            checks++; if (a_req_addr !== 32'h3000 || a_req_wdata !== 32'hCAFE_F00D || a_req_wstrb !== 4'hF || a_req_we !== 1'b1) begin
                errors++; $display("FAIL stall_req_stable[%0d]: got %h/%h/%h/%b want 3000/cafef00d/f/1", i, a_req_addr, a_req_wdata, a_req_wstrb, a_req_we);
            end
            checks++; if (a_ready !== 1'b0) begin errors++; $display("FAIL stall_ready[%0d]: got %b want 0", i, a_ready); end
        end
        @(negedge clk);
        a_req_ready = 1;
        #1;
        checks++; if (a_ready !== 1'b1) begin errors++; $display("FAIL stall_release_ready: got %b want 1", a_ready); end
        @(negedge clk);
        checks++; if (a_req_valid !== 1'b0) begin errors++; $display("FAIL stall_handshake: got %b want 0", a_req_valid); end
        a_rsp_valid = 1;
        @(negedge clk);
        a_rsp_valid = 0;
        checks++; if (a_idle !== 1'b1) begin errors++; $display("FAIL stall_idle: got %b want 1", a_idle); end
        $display("stall: 3 wait cycles then handshake");
    endtask

    task automatic test_back_to_back_depth();
        @(negedge clk);
        a_idle_inputs();
        a_valid = 1; a_addr = 32'h10; a_size = 2; a_rd = 5'd7;
        @(negedge clk);
        a_addr = 32'h14; a_rd = 5'd9;
        #1;
        checks++; if (a_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready: got %b want 1", a_ready); end
        @(negedge clk);
        a_addr = 32'h18; a_rd = 5'd11;
        #1;
        checks++; if (a_ready !== 1'b0) begin errors++; $display("FAIL depth_full_ready: got %b want 0", a_ready); end
        @(negedge clk);
        checks++; if (a_req_valid !== 1'b0) begin errors++; $display("FAIL depth_req_drained: got %b want 0", a_req_valid); end
        a_rsp_valid = 1; a_rsp_rdata = 32'h1111_1111;
        #1;
        checks++; if (a_ready !== 1'b0) begin errors++; $display("FAIL depth_rsp_ready: got %b want 0", a_ready); end
        @(negedge clk);
        a_rsp_valid = 0;
        checks++; if (a_wb_valid !== 1'b1 || a_wb_rd !== 5'd7 || a_wb_data !== 32'h1111_1111) begin
            errors++; $display("FAIL depth_wb0: got v=%b rd=%0d d=%h want v=1 rd=7 d=11111111", a_wb_valid, a_wb_rd, a_wb_data);
        end
        #1;
        checks++; if (a_ready !== 1'b1) begin errors++; $display("FAIL depth_reopen_ready: got %b want 1", a_ready); end
        @(negedge clk);
        a_valid = 0;
        #1;
        checks++; if (a_req_valid !== 1'b1 || a_req_addr !== 32'h18) begin errors++; $display("FAIL depth_third_req: got v=%b a=%h want v=1 a=18", a_req_valid, a_req_addr); end
        checks++; if (a_ready !== 1'b0) begin errors++; $display("FAIL depth_refull_ready: got %b want 0", a_ready); end
        @(negedge clk);
        a_rsp_valid = 1; a_rsp_rdata = 32'h2222_2222;
        @(negedge clk);
        checks++; if (a_wb_valid !== 1'b1 || a_wb_rd !== 5'd9 || a_wb_data !== 32'h2222_2222) begin
            errors++; $display("FAIL depth_wb1: got v=%b rd=%0d d=%h want v=1 rd=9 d=22222222", a_wb_valid, a_wb_rd, a_wb_data);
        end
        a_rsp_valid = 1; a_rsp_rdata = 32'h3333_3333;
        @(negedge clk);
        a_rsp_valid = 0;
        checks++; if (a_wb_valid !== 1'b1 || a_wb_rd !== 5'd11 || a_wb_data !== 32'h3333_3333) begin
            errors++; $display("FAIL depth_wb2: got v=%b rd=%0d d=%h want v=1 rd=11 d=33333333", a_wb_valid, a_wb_rd, a_wb_data);
        end
        @(negedge clk);
        checks++; if (a_idle !== 1'b1) begin errors++; $display("FAIL depth_idle: got %b want 1", a_idle); end
        $display("back_to_back_depth: rd order 7,9,11");
    endtask

    task automatic test_misaligned();
        @(negedge clk);
        a_idle_inputs();
        a_valid = 1; a_addr = 32'h1002; a_size = 2; a_rd = 5'd4;
        @(negedge clk);
        a_valid = 0;
        checks++; if (a_mis !== 1'b1) begin errors++; $display("FAIL mis_pulse: got %b want 1", a_mis); end
        checks++; if (a_exc_addr !== 32'h1002) begin errors++; $display("FAIL mis_exc_addr: got %h want 00001002", a_exc_addr); end
        checks++; if (a_req_valid !== 1'b0) begin errors++; $display("FAIL mis_no_req: got %b want 0", a_req_valid); end
        checks++; if (a_idle !== 1'b1) begin errors++; $display("FAIL mis_count0: got %b want 1", a_idle); end
        @(negedge clk);
        checks++; if (a_mis !== 1'b0) begin errors++; $display("FAIL mis_pulse_end: got %b want 0", a_mis); end
        checks++; if (a_exc_addr !== 32'h1002) begin errors++; $display("FAIL mis_exc_hold: got %h want 00001002", a_exc_addr); end
        $display("misaligned: lw at 1002");
    endtask

    task automatic test_random();
        req_t        exp_req[$];
        meta_t       meta[$];
        req_t        r;
        meta_t       m;
        int          bus_out;
        bit          exp_wb_valid, exp_mis, model_ready, rsp, drain;
        logic [4:0]  exp_wb_rd;
        logic [31:0] exp_wb_data, exp_exc;
        int          off, n_ld, n_st, n_mis;
        bus_out = 0; exp_wb_valid = 0; exp_mis = 0; exp_wb_rd = '0; exp_wb_data = '0; exp_exc = '0;
        n_ld = 0; n_st = 0; n_mis = 0;
        for (int cyc = 0; cyc < 640; cyc++) begin
            @(negedge clk);
            drain = (cyc >= 600);
            checks++; if (a_wb_valid !== exp_wb_valid) begin errors++; $display("FAIL rnd_wb_valid c%0d: got %b want %b", cyc, a_wb_valid, exp_wb_valid); end
            if (exp_wb_valid) begin
                checks++; if (a_wb_rd !== exp_wb_rd || a_wb_data !== exp_wb_data) begin
                    errors++; $display("FAIL rnd_wb c%0d: got rd=%0d d=%h want rd=%0d d=%h", cyc, a_wb_rd, a_wb_data, exp_wb_rd, exp_wb_data);
                end
            end
            checks++; if (a_mis !== exp_mis) begin errors++; $display("FAIL rnd_mis c%0d: got %b want %b", cyc, a_mis, exp_mis); end
            if (exp_mis) begin
                checks++; if (a_exc_addr !== exp_exc) begin errors++; $display("FAIL rnd_exc c%0d: got %h want %h", cyc, a_exc_addr, exp_exc); end
            end
            checks++; if (a_req_valid !== (exp_req.size() != 0)) begin errors++; $display("FAIL rnd_req_valid c%0d: got %b want %b", cyc, a_req_valid, exp_req.size() != 0); end
            if (exp_req.size() != 0) begin
                r = exp_req[0];
                checks++; if (a_req_addr !== r.addr || a_req_wdata !== r.wdata || a_req_wstrb !== r.wstrb || a_req_we !== r.we) begin
                    errors++; $display("FAIL rnd_req c%0d: got %h/%h/%h/%b want %h/%h/%h/%b", cyc, a_req_addr, a_req_wdata, a_req_wstrb, a_req_we, r.addr, r.wdata, r.wstrb, r.we);
                end
            end
            checks++; if (a_idle !== (meta.size() == 0)) begin errors++; $display("FAIL rnd_idle c%0d: got %b want %b", cyc, a_idle, meta.size() == 0); end

            a_valid     = drain ? 1'b0 : ($urandom_range(0, 3) != 0);
            a_size      = 2'($urandom_range(0, 3));
            a_addr      = 32'h4000 + 32'($urandom_range(0, 63));
            a_we        = 1'($urandom);
            a_sig       = 1'($urandom);
            a_rd        = 5'($urandom);
            a_wdata     = $urandom;
            a_req_ready = drain ? 1'b1 : ($urandom_range(0, 3) != 0);
            rsp         = (bus_out > 0) && (drain || $urandom_range(0, 2) != 0);
            a_rsp_valid = rsp;
            a_rsp_rdata = $urandom;
            #1;
            model_ready = (meta.size() < 2) && (exp_req.size() == 0 || a_req_ready);
            checks++; if (a_ready !== model_ready) begin errors++; $display("FAIL rnd_ready c%0d: got %b want %b", cyc, a_ready, model_ready); end

            exp_wb_valid = 0;
            exp_mis      = 0;
            if (rsp) begin
                m = meta.pop_front();
                bus_out--;
                if (!m.we) begin
                    exp_wb_valid = 1;
                    exp_wb_rd    = m.rd;
                    exp_wb_data  = 32'(model_extend(64'(a_rsp_rdata), m.off, m.size, m.sig));
                end
            end
            if (exp_req.size() != 0 && a_req_ready) begin
                void'(exp_req.pop_front());
                bus_out++;
            end
            if (a_valid && model_ready) begin
                if (model_misaligned32(a_addr, int'(a_size))) begin
                    exp_mis = 1; exp_exc = a_addr; n_mis++;
                end else begin
                    off     = int'(a_addr % 4);
                    r.addr  = a_addr - 32'(off);
                    r.wdata = a_wdata << (8 * off);
                    r.wstrb = 4'(((1 << (1 << a_size)) - 1) << off);
                    r.we    = a_we;
                    exp_req.push_back(r);
                    m.off = off; m.size = int'(a_size); m.sig = a_sig; m.we = a_we; m.rd = a_rd;
                    meta.push_back(m);
                    if (a_we) n_st++; else n_ld++;
                end
            end
        end
        @(negedge clk);
        a_idle_inputs();
        checks++; if (a_idle !== 1'b1) begin errors++; $display("FAIL rnd_drain_idle: got %b want 1", a_idle); end
        $display("random: loads=%0d stores=%0d misaligned=%0d", n_ld, n_st, n_mis);
    endtask

    task automatic test_xlen64();
        @(negedge clk);
        b_idle_inputs();
        b_valid = 1; b_addr = 64'h8; b_size = 3; b_we = 1; b_wdata = 64'h0123_4567_89AB_CDEF;
        @(negedge clk);
        b_valid = 0;
        checks++; if (b_req_valid !== 1'b1 || b_req_addr !== 64'h8) begin errors++; $display("FAIL sd_req: got v=%b a=%h want v=1 a=8", b_req_valid, b_req_addr); end
        checks++; if (b_req_wstrb !== 8'hFF) begin errors++; $display("FAIL sd_wstrb: got %h want ff", b_req_wstrb); end
        checks++; if (b_req_wdata !== 64'h0123_4567_89AB_CDEF) begin errors++; $display("FAIL sd_wdata: got %h want 0123456789abcdef", b_req_wdata); end
        @(negedge clk);
        b_rsp_valid = 1;
        @(negedge clk);
        b_rsp_valid = 0;
        checks++; if (b_wb_valid !== 1'b0) begin errors++; $display("FAIL sd_no_wb: got %b want 0", b_wb_valid); end

        b_valid = 1; b_addr = 64'h8; b_size = 3; b_we = 0; b_sig = 1; b_rd = 5'd3;
        @(negedge clk);
        b_valid = 0;
        @(negedge clk);
        b_rsp_valid = 1; b_rsp_rdata = 64'hDEAD_BEEF_0123_4567;
        @(negedge clk);
        b_rsp_valid = 0;
        checks++; if (b_wb_valid !== 1'b1 || b_wb_rd !== 5'd3 || b_wb_data !== 64'hDEAD_BEEF_0123_4567) begin
            errors++; $display("FAIL ld_wb: got v=%b rd=%0d d=%h want v=1 rd=3 d=deadbeef01234567", b_wb_valid, b_wb_rd, b_wb_data);
        end

        b_valid = 1; b_addr = 64'hC; b_size = 2; b_we = 0; b_sig = 1; b_rd = 5'd6;
        @(negedge clk);
        b_valid = 0;
        checks++; if (b_req_addr !== 64'h8) begin errors++; $display("FAIL lw64_addr: got %h want 8", b_req_addr); end
        @(negedge clk);
        b_rsp_valid = 1; b_rsp_rdata = 64'h8000_0000_0000_0000;
        @(negedge clk);
        b_rsp_valid = 0;
        checks++; if (b_wb_valid !== 1'b1 || b_wb_data !== 64'hFFFF_FFFF_8000_0000) begin
            errors++; $display("FAIL lw64_wb: got v=%b d=%h want v=1 d=ffffffff80000000", b_wb_valid, b_wb_data);
        end

        b_valid = 1; b_addr = 64'h4; b_size = 3; b_we = 0;
        @(negedge clk);
        b_valid = 0;
        checks++; if (b_mis !== 1'b1 || b_exc_addr !== 64'h4 || b_req_valid !== 1'b0) begin
            errors++; $display("FAIL ld64_mis: got m=%b e=%h rv=%b want m=1 e=4 rv=0", b_mis, b_exc_addr, b_req_valid);
        end
        $display("xlen64: sd/ld/lw/misaligned ld done");
    endtask

    task automatic test_reset_inflight();
        @(negedge clk);
        b_idle_inputs();
        b_valid = 1; b_addr = 64'h0; b_size = 3; b_rd = 5'd1;
        @(negedge clk);
        b_addr = 64'h8; b_rd = 5'd2;
        @(negedge clk);
        b_valid = 0;
        checks++; if (b_idle !== 1'b0 || b_ready !== 1'b0) begin errors++; $display("FAIL rst_pre_full: got idle=%b ready=%b want 0/0", b_idle, b_ready); end
        rst = 1;
        @(negedge clk);
        rst = 0;
        checks++; if (b_idle !== 1'b1) begin errors++; $display("FAIL rst_idle: got %b want 1", b_idle); end
        checks++; if (b_req_valid !== 1'b0 || b_wb_valid !== 1'b0 || b_mis !== 1'b0) begin
            errors++; $display("FAIL rst_valids: got rv=%b wb=%b m=%b want 0/0/0", b_req_valid, b_wb_valid, b_mis);
        end
        checks++; if (b_ready !== 1'b1) begin errors++; $display("FAIL rst_ready: got %b want 1", b_ready); end
        b_rsp_valid = 1; b_rsp_rdata = 64'h1234_5678_9ABC_DEF0;
        @(negedge clk);
        b_rsp_valid = 0;
        checks++; if (b_wb_valid !== 1'b0) begin errors++; $display("FAIL rst_late_rsp: got %b want 0", b_wb_valid); end
        checks++; if (b_idle !== 1'b1) begin errors++; $display("FAIL rst_late_idle: got %b want 1", b_idle); end
        $display("reset_inflight: late response ignored");
    endtask

    initial begin
        test_reset();
        test_store_byte();
        test_load_byte(1'b1, 32'hFFFF_FF80);
        test_load_byte(1'b0, 32'h0000_0080);
        test_stall();
        test_back_to_back_depth();
        test_misaligned();
        test_random();
        test_xlen64();
        test_reset_inflight();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
